// File: rtl/ne_decoder_pkg.sv
// Shared NE decoder constants, unload FSM state type and beat-count helpers.
// Pure declarations: no latency and no flow control of its own.
package ne_decoder_pkg;

  localparam int NE_KB           = 14;
  localparam int NE_HDWIDTH      = 32;
  localparam int NE_ADDRESSWIDTH = 5;
  localparam int NE_UNLOADCOUNT  = 17;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } ne_unload_state_t;

  function automatic int ne_beats(input int rowbits, input int outw);
    return rowbits / outw;
  endfunction

  // Width of a counter holding values 0..n-1.
  function automatic int ne_cntw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ne_row_fifo.sv
// Synchronous row FIFO with show-ahead head, count, full and empty flags.
// Head is visible the cycle after a write. The caller must not write when full.
module ne_row_fifo #(
  parameter int W     = 448,
  parameter int DEPTH = 4,
  parameter int CNTW  = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_wr_vld,
  input  logic [W-1:0]    i_wr_dat,
  input  logic            i_pop,
  output logic [W-1:0]    o_head,
  output logic [CNTW-1:0] o_count,
  output logic            o_full,
  output logic            o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]    r_mem [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CNTW-1:0] r_count;
  logic            w_rd;

  assign w_rd    = i_pop && !o_empty;
  assign o_head  = r_mem[r_rptr];
  assign o_count = r_count;
  assign o_full  = (r_count == CNTW'(DEPTH));
  assign o_empty = (r_count == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_wr_vld) begin
        r_mem[r_wptr] <= i_wr_dat;
        r_wptr        <= r_wptr + AW'(1);
      end
      if (w_rd) r_rptr <= r_rptr + AW'(1);
      // Simultaneous write and pop leaves the count unchanged.
      case ({i_wr_vld, w_rd})
        2'b10:   r_count <= r_count + CNTW'(1);
        2'b01:   r_count <= r_count - CNTW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ne_hd_unload_ctrl.sv
// HD unload controller: credit-paced core reads into a row FIFO, serialised to OUTW-bit valid/ready beats.
// First beat RDLAT+2 cycles after unload_start; reads stall on credits; NE_HDOUT_BITREV_EN bit-reverses each beat.
module ne_hd_unload_ctrl
  import ne_decoder_pkg::*;
#(
  parameter int Kb           = NE_KB,
  parameter int HDWIDTH      = NE_HDWIDTH,
  parameter int ADDRESSWIDTH = NE_ADDRESSWIDTH,
  parameter int UNLOADCOUNT  = NE_UNLOADCOUNT,
  parameter int RDLAT        = 2,
  parameter int FIFODEPTH    = 4,
  parameter int OUTW         = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    unload_start,
  output logic                    unload_en,
  output logic [ADDRESSWIDTH-1:0] unload_addr,
  input  logic [Kb*HDWIDTH-1:0]   wrdin_vec,
  output logic [OUTW-1:0]         hd_out,
  output logic                    hd_valid,
  input  logic                    hd_ready,
  output logic                    hd_sof,
  output logic                    hd_eof,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    start_drop
);
  localparam int ROWW  = Kb * HDWIDTH;
  localparam int BEATS = ne_beats(ROWW, OUTW);
  localparam int BW    = ne_cntw(BEATS);
  localparam int RW    = ne_cntw(UNLOADCOUNT);
  localparam int CNTW  = $clog2(FIFODEPTH) + 1;

  ne_unload_state_t        r_state;
  ne_unload_state_t        w_next;
  logic [ADDRESSWIDTH-1:0] r_addr;
  logic [RDLAT-1:0]        r_vpipe;
  logic [BW-1:0]           r_beat;
  logic [RW-1:0]           r_orow;
  logic                    r_done;

  logic [ROWW-1:0]         w_head;
  logic [CNTW-1:0]         w_fifo_cnt;
  logic                    w_full;
  logic                    w_empty;
  logic                    w_fifo_wr;
  logic                    w_pop;
  logic                    w_acc;
  logic                    w_last_beat;
  logic                    w_last_row;
  logic                    w_last_acc;
  logic                    w_start_ok;
  logic                    w_credit_ok;
  logic                    w_last_addr;
  int                      w_inflight;
  logic [OUTW-1:0]         w_slice;
  logic [OUTW-1:0]         w_beat_dat;

  // The frame_done cycle is IDLE but still refuses a new start.
  assign w_start_ok  = unload_start && (r_state == ST_IDLE) && !r_done;
  assign w_last_addr = (r_addr == ADDRESSWIDTH'(UNLOADCOUNT - 1));
  assign w_last_beat = (r_beat == BW'(BEATS - 1));
  assign w_last_row  = (r_orow == RW'(UNLOADCOUNT - 1));
  assign w_acc       = hd_valid && hd_ready;
  assign w_pop       = w_acc && w_last_beat;
  assign w_last_acc  = w_acc && w_last_beat && w_last_row;
  assign w_fifo_wr   = r_vpipe[RDLAT-1] && !w_full;

  always_comb begin
    w_inflight = 0;
    for (int i = 0; i < RDLAT; i++) w_inflight = w_inflight + int'(r_vpipe[i]);
    w_credit_ok = (int'(w_fifo_cnt) + w_inflight) < FIFODEPTH;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_start_ok) w_next = ST_ISSUE;
      ST_ISSUE: if (unload_en && w_last_addr) w_next = ST_DRAIN;
      ST_DRAIN: if (w_last_acc && (w_inflight == 0) && (w_fifo_cnt == CNTW'(1))) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    unload_en   = (r_state == ST_ISSUE) && w_credit_ok;
    unload_addr = r_addr;
    busy        = (r_state != ST_IDLE);
    start_drop  = unload_start && !((r_state == ST_IDLE) && !r_done);
    frame_done  = r_done;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr  <= '0;
      r_vpipe <= '0;
      r_beat  <= '0;
      r_orow  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= (r_state == ST_DRAIN) && (w_next == ST_IDLE);
      if (unload_en) r_addr <= w_last_addr ? '0 : r_addr + ADDRESSWIDTH'(1);
      r_vpipe[0] <= unload_en;
      for (int i = 1; i < RDLAT; i++) r_vpipe[i] <= r_vpipe[i-1];
      if (w_acc) begin
        if (w_last_beat) begin
          r_beat <= '0;
          r_orow <= w_last_row ? '0 : r_orow + RW'(1);
        end else begin
          r_beat <= r_beat + BW'(1);
        end
      end
    end
  end

  ne_row_fifo #(
    .W     (ROWW),
    .DEPTH (FIFODEPTH),
    .CNTW  (CNTW)
  ) u_row_fifo (
    .clk      (clk),
    .rst      (rst),
    .i_wr_vld (w_fifo_wr),
    .i_wr_dat (wrdin_vec),
    .i_pop    (w_pop),
    .o_head   (w_head),
    .o_count  (w_fifo_cnt),
    .o_full   (w_full),
    .o_empty  (w_empty)
  );

  always_comb begin
    w_slice = w_head[int'(r_beat)*OUTW +: OUTW];
`ifdef NE_HDOUT_BITREV_EN
    w_beat_dat = {<<{w_slice}};
`else
    w_beat_dat = w_slice;
`endif
  end

  assign hd_valid = !w_empty;
  assign hd_out   = hd_valid ? w_beat_dat : '0;
  assign hd_sof   = hd_valid && (r_orow == '0) && (r_beat == '0);
  assign hd_eof   = hd_valid && w_last_row && w_last_beat;

endmodule

// File: doc/ne_hd_unload_ctrl.md
# ne_hd_unload_ctrl

Single-clock, parametrised hard-decision unload controller for the NE LDPC decoder. It sits between the decoder core's unload port and the downstream sink. On an `unload_start` pulse it walks the core's HD row addresses and captures the returned `Kb*HDWIDTH`-bit rows into a small row FIFO. It then serialises each row into `OUTW`-bit beats on a valid/ready stream. This replaces fixed wait-cycle clock-crossing pacing with credit-based backpressure, and adds frame delimiting and a configurable output width.

## Interface
Parameters:
- `Kb`, 14, systematic circulant columns per row.
- `HDWIDTH`, 32, HD bits per column.
- `ADDRESSWIDTH`, 5, core unload address width.
- `UNLOADCOUNT`, 17, rows per frame; must be ≤ 2^ADDRESSWIDTH.
- `RDLAT`, 2, cycles from `unload_en`/`unload_addr` to valid `wrdin_vec`; must be ≥ 1.
- `FIFODEPTH`, 4, row FIFO entries; must be a power of 2 and ≥ 2.
- `OUTW`, 32, output beat width; must divide `Kb*HDWIDTH`. BEATS = `Kb*HDWIDTH/OUTW`.

Ports:
- `clk` in 1: decoder clock.
- `rst` in 1: asynchronous, active-high reset.
- `unload_start` in 1: single-cycle frame start from the decoder core.
- `unload_en` out 1: core read strobe.
- `unload_addr` out ADDRESSWIDTH: core row address.
- `wrdin_vec` in Kb*HDWIDTH: core HD row, valid RDLAT cycles after `unload_en`.
- `hd_out` out OUTW: output beat.
- `hd_valid` out 1: beat valid.
- `hd_ready` in 1: sink ready.
- `hd_sof` out 1: first beat of frame, qualified by `hd_valid`.
- `hd_eof` out 1: last beat of frame, qualified by `hd_valid`.
- `busy` out 1: high in any state except IDLE.
- `frame_done` out 1: one-cycle pulse after the final beat is accepted.
- `start_drop` out 1: one-cycle pulse when `unload_start` arrives while not IDLE.

## Operation
- FSM states and transitions:
  - IDLE → ISSUE on `unload_start`.
  - ISSUE → DRAIN when read UNLOADCOUNT−1 is issued.
  - DRAIN → IDLE when the FIFO is empty, no reads are in flight, and the last beat is accepted.
- Credit rule: `unload_en` = ISSUE && (fifo_count + inflight < FIFODEPTH). `unload_addr` increments per issued read, from 0 to UNLOADCOUNT−1.
- Capture: an RDLAT-deep valid shift register tracks `unload_en`. Its tail writes `wrdin_vec` into the FIFO. The credit rule guarantees the FIFO never overflows; any overflow is a design error.
- Serialiser: beat index b runs 0..BEATS−1 over the FIFO head. `hd_out` = head[b*OUTW +: OUTW], LSB slice first. b advances on `hd_valid && hd_ready`. The head is popped on acceptance of beat BEATS−1.
- An output row counter drives `hd_sof` (row 0, b=0) and `hd_eof` (row UNLOADCOUNT−1, b=BEATS−1).
- `unload_start` is accepted only in IDLE. In any other state it is ignored and `start_drop` pulses. This includes the `frame_done` cycle.
- Simultaneous FIFO write and pop in one cycle: count is unchanged and both operations take effect.
- The ready handshake is AXI-style. `hd_out`, `hd_sof` and `hd_eof` hold stable while `hd_valid && !hd_ready`.

## Timing
- Reset values: `unload_en`=0, `unload_addr`=0, `hd_out`=0, `hd_valid`=0, `hd_sof`=0, `hd_eof`=0, `busy`=0, `frame_done`=0, `start_drop`=0. FIFO, counters and the valid pipe are cleared.
- Reset mid-frame aborts immediately. In-flight returns are discarded because the valid pipe is cleared.
- `unload_start` at edge t:
  - `busy` and the first `unload_en` at t+1.
  - FIFO write at t+1+RDLAT.
  - First `hd_valid` at t+2+RDLAT.
- Throughput: one beat per cycle while `hd_ready`=1. Reads are throttled by credits only.
- `frame_done` is asserted the cycle after the `hd_eof` beat is accepted, together with the return to IDLE (`busy`=0).

## Configuration
- `NE_HDOUT_BITREV_EN`:
  - Defined: each `hd_out` beat is bit-reversed, so slice bit 0 appears on `hd_out[OUTW-1]`.
  - Undefined: slices are output unchanged.
- Neither setting affects handshake or timing.

## Structure
- Shared package `ne_decoder_pkg`:
  - Kb, HDWIDTH, UNLOADCOUNT, ADDRESSWIDTH constants.
  - FSM state typedef (IDLE/ISSUE/DRAIN).
  - A function computing BEATS and its counter width.
- One sub-module: `ne_row_fifo`, a synchronous FIFO of Kb*HDWIDTH-bit rows, FIFODEPTH deep, providing count, full and empty.
- FSM, credit logic, valid pipe and serialiser stay in the top.

## Test plan
- Defaults, `hd_ready`=1, core model returns row r = {14{r[4:0] replicated to 32 bits}}, start at t:
  - First valid at t+4 with `hd_sof`=1.
  - 238 beats in total.
  - `hd_eof` on beat 237.
  - `frame_done` one cycle later.
  - Data matches the model.
- `hd_ready` held low for 100 cycles after start:
  - Exactly 4 `unload_en` pulses (addresses 0–3), then `unload_en` stays 0.
  - No FIFO overflow.
  - Releasing ready completes the frame intact.
- Random `hd_ready` at 30% high:
  - Beat sequence equals the golden stream.
  - Outputs stable while stalled.
- `unload_start` pulsed mid-frame and on the `frame_done` cycle → `start_drop` pulses each time and the frame is unaffected.
- `rst` asserted at beat 50, then a new start → outputs return to reset values immediately, and the new frame begins at address 0 with `hd_sof`.
- OUTW=64, RDLAT=3, `NE_HDOUT_BITREV_EN` defined → 119 beats per frame, each beat equal to the bit-reversed 64-bit slice.
